serial_parity_accumulator: RTL and testbench

//  Downstream consumer of the XOR primitives. Accepts a stream of DATA_W-bit words over a

---
 rtl/serial_parity_accumulator_pkg.sv | 18 +
 rtl/serial_parity_accumulator_if.sv | 34 +++
 rtl/serial_parity_accumulator_parity_reduce.sv | 14 +
 rtl/serial_parity_accumulator.sv | 134 +++++++++++++
 tb/tb_serial_parity_accumulator.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_parity_accumulator_pkg.sv
// Shared types for the serial parity accumulator and the parity checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_parity_accumulator_pkg;

   // Frame FSM encoding. The parity checker uses the same values, so they stay fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Width of a word counter that must be able to represent FRAME_LEN itself.
   function automatic int cnt_width(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

endpackage

// File: rtl/serial_parity_accumulator_if.sv
// Word-in / frame-result-out bundle for the serial parity accumulator.
// Latency: n/a (wiring only).
// Backpressure: in_ready stalls the word producer; out_ready stalls the result.
interface serial_parity_accumulator_if
   import serial_parity_accumulator_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int FRAME_LEN = 4
);
   localparam int CNT_W = cnt_width(FRAME_LEN);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_lane_parity;
   logic              out_parity;
   logic [CNT_W-1:0]  out_count;

   // Producer of words and consumer of frame results.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_lane_parity, out_parity, out_count
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_lane_parity, out_parity, out_count
   );

endinterface

// File: rtl/serial_parity_accumulator_parity_reduce.sv
// XOR-reduce of a DATA_W-bit vector down to a single even-parity bit.
// Latency: combinational.
// Backpressure: none.
module parity_reduce #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] vec,
   output logic              par
);

   // One when the vector carries an odd number of set bits.
   assign par = ^vec;

endmodule

// File: rtl/serial_parity_accumulator.sv
// XOR-folds a word stream per frame (FRAME_LEN words or in_last) into lane/overall parity + count.
// Latency: result valid 1 cycle after the closing word is accepted.
// Backpressure: in_ready low while a result waits for out_ready; no frame overlap.
module serial_parity_accumulator
   import serial_parity_accumulator_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FRAME_LEN  = 4,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   serial_parity_accumulator_if.slave  bus
);

   localparam int               CNT_W    = cnt_width(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state;
   state_t            state_nxt;

   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  cnt;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_lane_q;
   logic              out_parity_q;
   logic [CNT_W-1:0]  out_count_q;

   logic              in_ready;
   logic              accept;
   logic              closing;
   logic              release_result;
   logic [DATA_W-1:0] fold;
   logic              fold_par;

   // in_ready is forced low during reset so nothing is taken while the block is cleared.
   assign in_ready       = rst_n & (state != ST_HOLD);
   assign accept         = bus.in_valid & in_ready;
   // A word closes the frame when flagged as last or when it fills the frame.
   assign closing        = bus.in_last | (cnt == LAST_IDX);
   assign release_result = out_valid_q & bus.out_ready;
   assign fold           = acc ^ bus.in_data;

   parity_reduce #(
      .DATA_W (DATA_W)
   ) u_parity_reduce (
      .vec (fold),
      .par (fold_par)
   );

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next frame state: collect words until a closing word, then hold until the result is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               state_nxt = closing ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (release_result) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Running fold and word count of the open frame; both clear once the frame closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (closing) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= fold;
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // Result registers: loaded by the closing word, held until the downstream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_lane_q   <= '0;
         out_parity_q <= 1'b0;
         out_count_q  <= '0;
      end else if (accept && closing) begin
         out_valid_q  <= 1'b1;
         out_lane_q   <= fold;
         out_parity_q <= fold_par ^ ODD_PARITY;
         out_count_q  <= cnt + CNT_ONE;
      end else if (release_result) begin
         out_valid_q  <= 1'b0;
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_lane_parity = out_lane_q;
   assign bus.out_parity      = out_parity_q;
   assign bus.out_count       = out_count_q;

   // A pending result must not change until it has been taken.
   a_hold_stable: assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready) |=>
         (out_valid_q && $stable(out_lane_q) && $stable(out_parity_q) && $stable(out_count_q))
   );

   // The result flag and the HOLD state always agree.
   a_hold_matches_valid: assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid_q == (state == ST_HOLD))
   );

endmodule

// File: tb/tb_serial_parity_accumulator.sv
// Randomised and directed stimulus against a frame-level reference model (word queue + XOR).
// Two DUTs share the stimulus: one even parity, one odd parity.
module tb_serial_parity_accumulator;

   localparam int DATA_W    = 8;
   localparam int FRAME_LEN = 4;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_parity_accumulator_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus_e ();
   serial_parity_accumulator_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus_o ();

   serial_parity_accumulator #(
      .DATA_W (DATA_W), .FRAME_LEN (FRAME_LEN), .ODD_PARITY (1'b0)
   ) dut_even (
      .clk (clk), .rst_n (rst_n), .bus (bus_e.slave)
   );

   serial_parity_accumulator #(
      .DATA_W (DATA_W), .FRAME_LEN (FRAME_LEN), .ODD_PARITY (1'b1)
   ) dut_odd (
      .clk (clk), .rst_n (rst_n), .bus (bus_o.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: words of the open frame, and the pending frame result if any.
   logic [DATA_W-1:0] words[$];
   bit                hold;
   logic [DATA_W-1:0] exp_lane;
   int                exp_cnt;
   bit                exp_par;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit ordy);
      bus_e.in_valid = v;  bus_o.in_valid = v;
      bus_e.in_data  = d;  bus_o.in_data  = d;
      bus_e.in_last  = l;  bus_o.in_last  = l;
      bus_e.out_ready = ordy; bus_o.out_ready = ordy;
   endtask

   task automatic model_clear();
      words.delete();
      hold = 1'b0;
   endtask

   // One clock: drive, check against the model at the falling edge, update the model at the rising edge.
   task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit ordy);
      logic [DATA_W-1:0] x;
      drive(v, d, l, ordy);
      @(negedge clk);
      check("in_ready_e", 32'(bus_e.in_ready), 32'(!hold));
      check("in_ready_o", 32'(bus_o.in_ready), 32'(!hold));
      check("out_valid_e", 32'(bus_e.out_valid), 32'(hold));
      check("out_valid_o", 32'(bus_o.out_valid), 32'(hold));
      if (hold) begin
         check("lane_e", 32'(bus_e.out_lane_parity), 32'(exp_lane));
         check("lane_o", 32'(bus_o.out_lane_parity), 32'(exp_lane));
         check("count_e", 32'(bus_e.out_count), 32'(exp_cnt));
         check("count_o", 32'(bus_o.out_count), 32'(exp_cnt));
         check("parity_e", 32'(bus_e.out_parity), 32'(exp_par));
         check("parity_o", 32'(bus_o.out_parity), 32'(!exp_par));
      end
      @(posedge clk);
      if (hold) begin
         if (ordy) hold = 1'b0;
      end else if (v) begin
         words.push_back(d);
         if (l || words.size() == FRAME_LEN) begin
            x = '0;
            foreach (words[i]) x = x ^ words[i];
            exp_lane = x;
            exp_cnt  = words.size();
            exp_par  = ^x;
            hold     = 1'b1;
            words.delete();
         end
      end
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},  32'(bus_e.out_valid), 32'd0);
      check({tag, "_lane"},   32'(bus_e.out_lane_parity), 32'd0);
      check({tag, "_parity"}, 32'(bus_o.out_parity), 32'd0);
      check({tag, "_count"},  32'(bus_e.out_count), 32'd0);
      check({tag, "_ready"},  32'(bus_e.in_ready), 32'd0);
   endtask

   // Asynchronous reset asserted between edges, held over one rising edge, released after it.
   task automatic reset_mid();
      drive(1'b0, '0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_zero("rst_async");
      model_clear();
      @(posedge clk);
      #1 check_zero("rst_held");
      rst_n = 1'b1;
   endtask

   logic [DATA_W-1:0] seq1 [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
   logic [DATA_W-1:0] seq5 [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

   initial begin
      model_clear();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      #1 check_zero("rst_init");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full frame, closed by length.
      foreach (seq1[i]) cycle(1'b1, seq1[i], 1'b0, 1'b1);
      #1;
      check("t1_valid", 32'(bus_e.out_valid), 32'd1);
      check("t1_lane", 32'(bus_e.out_lane_parity), 32'h67);
      check("t1_parity", 32'(bus_e.out_parity), 32'd1);
      check("t1_count", 32'(bus_e.out_count), 32'd4);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Single-word frame closed by in_last.
      cycle(1'b1, 8'h0F, 1'b1, 1'b0);
      #1;
      check("t2_lane", 32'(bus_e.out_lane_parity), 32'h0F);
      check("t2_parity", 32'(bus_e.out_parity), 32'd0);
      check("t2_count", 32'(bus_e.out_count), 32'd1);
      check("t2_ready", 32'(bus_e.in_ready), 32'd0);

      // Backpressure: offered words are refused while the result waits.
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b0, 1'b1);
      foreach (seq5[i]) cycle(1'b1, seq5[i], 1'b0, 1'b0);
      #1;
      check("t3_lane", 32'(bus_e.out_lane_parity), 32'h0F);
      check("t3_count", 32'(bus_e.out_count), 32'd4);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Idle bubbles between words.
      cycle(1'b1, 8'h11, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h55, 1'b1, 1'b1);
      cycle(1'b1, 8'h22, 1'b0, 1'b1);
      cycle(1'b1, 8'h44, 1'b0, 1'b1);
      cycle(1'b1, 8'h88, 1'b0, 1'b1);
      #1;
      check("t4_lane", 32'(bus_e.out_lane_parity), 32'hFF);
      check("t4_parity", 32'(bus_e.out_parity), 32'd0);
      check("t4_count", 32'(bus_e.out_count), 32'd4);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Reset mid-frame discards the partial fold.
      cycle(1'b1, 8'hF0, 1'b0, 1'b1);
      cycle(1'b1, 8'h3C, 1'b0, 1'b1);
      reset_mid();
      foreach (seq5[i]) cycle(1'b1, seq5[i], 1'b0, 1'b1);
      #1;
      check("t5_lane", 32'(bus_e.out_lane_parity), 32'h0F);
      check("t5_count", 32'(bus_e.out_count), 32'd4);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // All-zero frame: odd-parity instance reports 1.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00, 1'b0, 1'b1);
      #1;
      check("t6_lane", 32'(bus_o.out_lane_parity), 32'h00);
      check("t6_parity_odd", 32'(bus_o.out_parity), 32'd1);
      check("t6_parity_even", 32'(bus_e.out_parity), 32'd0);
      check("t6_count", 32'(bus_o.out_count), 32'd4);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Reset while a result is pending.
      cycle(1'b1, 8'h5A, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      reset_mid();

      // Randomised traffic with one reset in the middle.
      for (int n = 0; n < 600; n++) begin
         if (n == 300) reset_mid();
         cycle($urandom_range(0, 9) < 7, DATA_W'($urandom), $urandom_range(0, 4) == 0,
               $urandom_range(0, 9) < 6);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000");
      $fatal(1);
   end

endmodule
